// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S types for the receive and transmit paths
package i2s_pkg;

    localparam int I2S_DATA_W = 24;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        LEFT,
        RIGHT
    } rx_state_e;

    typedef struct packed {
        logic [I2S_DATA_W-1:0] left;
        logic [I2S_DATA_W-1:0] right;
    } stereo_frame_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// rtl/i2s_rx_fifo.sv - synchronous stereo-frame FIFO; a push into a full FIFO succeeds only alongside a pop
module i2s_rx_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push,
    input  stereo_frame_t push_data,
    input  logic          pop,
    output stereo_frame_t head,
    output logic          empty,
    output logic          full
);

    localparam int AW = $clog2(DEPTH);

    stereo_frame_t mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S capture receiver on the system clock; peak meter enabled by I2S_RX_PEAK_EN
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W      = I2S_DATA_W,
    parameter int SLOT_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCLK,
    input  logic              LRCLK,
    input  logic              Din,
    output logic [DATA_W-1:0] sample_left,
    output logic [DATA_W-1:0] sample_right,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overflow,
    output logic              frame_err,
    input  logic              clear_status,
    output logic [DATA_W-1:0] peak_left,
    output logic [DATA_W-1:0] peak_right,
    input  logic              peak_clear
);

    localparam int CNT_W = $clog2(SLOT_W + 2);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_W + 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   sclk_d;
    logic                   bit_ev;
    logic                   lr_bit;
    logic                   din_bit;

    rx_state_e         state;
    rx_state_e         state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_nx;
    logic [DATA_W-1:0] sreg_shift;
    logic              lr_prev;
    logic              lr_prev_nx;
    logic              fin_left_nx;
    logic              fin_right_nx;

    logic              fin_left;
    logic              fin_right;
    logic [DATA_W-1:0] fin_sreg;
    logic [CNT_W-1:0]  fin_cnt;
    logic [CNT_W-1:0]  pad;
    logic [DATA_W-1:0] fin_word;
    logic              fin_bad;
    logic [DATA_W-1:0] left_word;

    logic              push_q;
    stereo_frame_t     push_frame;
    stereo_frame_t     head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_pop;
    logic              drop;

    // Bit event is registered together with the LR/data bits it qualifies.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            din_sync  <= '0;
            sclk_d    <= 1'b0;
            bit_ev    <= 1'b0;
            lr_bit    <= 1'b0;
            din_bit   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], LRCLK};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], Din};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            bit_ev    <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            lr_bit    <= lr_sync[SYNC_STAGES-1];
            din_bit   <= din_sync[SYNC_STAGES-1];
        end
    end

    assign cnt_inc    = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    assign sreg_shift = (cnt < CNT_DATA) ? {sreg[DATA_W-2:0], din_bit} : sreg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= WAIT_SYNC;
            cnt       <= '0;
            sreg      <= '0;
            lr_prev   <= 1'b0;
            fin_left  <= 1'b0;
            fin_right <= 1'b0;
            fin_sreg  <= '0;
            fin_cnt   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sreg      <= sreg_nx;
            lr_prev   <= lr_prev_nx;
            fin_left  <= fin_left_nx;
            fin_right <= fin_right_nx;
            if (fin_left_nx || fin_right_nx) begin
                fin_sreg <= sreg_shift;
                fin_cnt  <= cnt_inc;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        sreg_nx      = sreg;
        lr_prev_nx   = lr_prev;
        fin_left_nx  = 1'b0;
        fin_right_nx = 1'b0;
        if (bit_ev) begin
            lr_prev_nx = lr_bit;
            case (state)
                WAIT_SYNC: begin
                    if (lr_prev && !lr_bit) begin
                        state_nx = LEFT;
                        cnt_nx   = '0;
                        sreg_nx  = '0;
                    end
                end
                LEFT: begin
                    sreg_nx = sreg_shift;
                    cnt_nx  = cnt_inc;
                    if (lr_bit) begin
                        fin_left_nx = 1'b1;
                        state_nx    = RIGHT;
                        cnt_nx      = '0;
                        sreg_nx     = '0;
                    end
                end
                RIGHT: begin
                    sreg_nx = sreg_shift;
                    cnt_nx  = cnt_inc;
                    if (!lr_bit) begin
                        fin_right_nx = 1'b1;
                        state_nx     = LEFT;
                        cnt_nx       = '0;
                        sreg_nx      = '0;
                    end
                end
                default: state_nx = WAIT_SYNC;
            endcase
        end
    end

    // Short slots are left-justified by padding zeros into the LSBs.
    assign pad      = CNT_DATA - fin_cnt;
    assign fin_word = (fin_cnt < CNT_DATA) ? (fin_sreg << pad) : fin_sreg;
    assign fin_bad  = (fin_cnt < CNT_DATA) || (fin_cnt > CNT_SLOT);

    assign fifo_pop = sample_valid && sample_ready;
    assign drop     = push_q && fifo_full && !fifo_pop;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            left_word  <= '0;
            push_q     <= 1'b0;
            push_frame <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            push_q <= fin_right;
            if (fin_left) begin
                left_word <= fin_word;
            end
            if (fin_right) begin
                push_frame.left  <= left_word;
                push_frame.right <= fin_word;
            end
            if ((fin_left || fin_right) && fin_bad) begin
                frame_err <= 1'b1;
            end else if (clear_status) begin
                frame_err <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_status) begin
                overflow <= 1'b0;
            end
        end
    end

    i2s_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RESET    (RESET),
        .push     (push_q),
        .push_data(push_frame),
        .pop      (fifo_pop),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign sample_valid = !fifo_empty;
    assign sample_left  = head.left;
    assign sample_right = head.right;

`ifdef I2S_RX_PEAK_EN
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] n;
        n = -x;
        if (!x[DATA_W-1]) begin
            return x;
        end
        // Most negative code has no positive twin; clamp to full-scale positive.
        if (n[DATA_W-1]) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
        return n;
    endfunction

    logic [DATA_W-1:0] mag_l;
    logic [DATA_W-1:0] mag_r;

    assign mag_l = mag(left_word);
    assign mag_r = mag(fin_word);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            peak_left  <= '0;
            peak_right <= '0;
        end else if (fin_right) begin
            peak_left  <= (peak_clear || (mag_l > peak_left))  ? mag_l : peak_left;
            peak_right <= (peak_clear || (mag_r > peak_right)) ? mag_r : peak_right;
        end else if (peak_clear) begin
            peak_left  <= '0;
            peak_right <= '0;
        end
    end
`else
    logic peak_clear_unused;

    assign peak_clear_unused = peak_clear;
    assign peak_left         = '0;
    assign peak_right        = '0;
`endif

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver: the capture-side counterpart of the audio output path. Takes the codec ADC stream (SCLK, LRCLK, Din) and delivers 24-bit left/right sample pairs.
- Runs entirely on the system clock. SCLK, LRCLK and Din are synchronised into CLK and SCLK edges are detected there, so there is no second clock domain.
- Completed stereo frames go into a small FIFO with a valid/ready handshake, consumed by the filter path or a bus-mapped reader.

Parameters:
- DATA_W, 24, captured sample width (MSB-first, left-justified in slot)
- SLOT_W, 32, maximum legal SCLK bits per channel slot
- FIFO_DEPTH, 4, stereo frames buffered (power of 2)
- SYNC_STAGES, 2, synchroniser flops on SCLK/LRCLK/Din

Ports:
- CLK  in  1  system clock, must be ≥ 4× SCLK; SCLK high and low phases ≥ 2 CLK each
- RESET  in  1  synchronous, active-high
- SCLK  in  1  I2S bit clock, asynchronous
- LRCLK  in  1  word select, asynchronous; 0 = left, 1 = right
- Din  in  1  serial data, asynchronous
- sample_left  out  DATA_W  FIFO head, left sample
- sample_right  out  DATA_W  FIFO head, right sample
- sample_valid  out  1  FIFO not empty
- sample_ready  in  1  consumer accepts head
- overflow  out  1  sticky: a frame was dropped because the FIFO was full
- frame_err  out  1  sticky: slot shorter than DATA_W bits or longer than SLOT_W bits
- clear_status  in  1  clears overflow and frame_err
- peak_left  out  DATA_W  optional peak meter, left
- peak_right  out  DATA_W  optional peak meter, right
- peak_clear  in  1  optional peak meter clear

Behaviour:
- Reset: FIFO empty, all outputs 0, shift register and counter 0, FSM = WAIT_SYNC. A reset mid-word discards the partial word; capture restarts at the next left slot.
- Synchronisation: SCLK, LRCLK and Din each pass through SYNC_STAGES flops.
- Bit event: a synchronised SCLK 0→1 transition. At each bit event, Din_s and LRCLK_s are sampled; lr_prev holds LRCLK_s from the previous bit event.
- Framing (standard I2S, one-bit delay): the bit event at which LRCLK_s != lr_prev carries the LSB of the OLD channel. The MSB of the new channel arrives on the following bit event.
- FSM states WAIT_SYNC, LEFT, RIGHT:
  - WAIT_SYNC: bits ignored. On a bit event with lr_prev=1, LRCLK_s=0 → go to LEFT, cnt=0; the current bit is discarded.
  - LEFT, bit event, LRCLK_s=0: if cnt<DATA_W, shift Din_s in; cnt increments, saturating at SLOT_W+1.
  - LEFT, bit event, LRCLK_s=1: process the current bit as above, finalise the left word, go to RIGHT, cnt=0.
  - RIGHT: symmetric. On LRCLK_s 1→0: finalise the right word, push {left,right} to the FIFO, go to LEFT, cnt=0.
- Finalise rules:
  - Word = shift register left-justified. If bits received < DATA_W, the value is shifted up and zero-padded in the LSBs, and frame_err is set.
  - If cnt > SLOT_W, frame_err is set and the word is still delivered.
  - Bits beyond DATA_W are ignored.
- Latency: with an empty FIFO, sample_valid rises exactly SYNC_STAGES+3 CLK cycles after the first CLK edge that registers SCLK high for the right-channel LSB bit event.
- FIFO handshake:
  - Head is shown while sample_valid=1.
  - Pop occurs when sample_valid && sample_ready.
  - Push when full: the new frame is dropped, the FIFO is unchanged, and overflow is set.
  - Push and pop in the same cycle when full: both happen; overflow is not set.
  - Output order is strictly FIFO.
- Status flags: clear_status and a set event in the same cycle → the set wins.

Optional Feature:
- Macro: I2S_RX_PEAK_EN.
- With the macro:
  - On every finalised frame (including dropped ones), peak_x = max(peak_x, |sample_x|).
  - |.| is the two's-complement magnitude; 0x800000 saturates to 0x7FFFFF.
  - peak_clear zeroes both peaks. If clear and update occur in the same cycle, the peak loads |sample|.
- Without the macro: peak ports are present and tied to 0; peak_clear is ignored. The interface is identical in both builds.

Decomposition:
- Package i2s_pkg:
  - I2S_DATA_W constant
  - rx_state_e enum (WAIT_SYNC, LEFT, RIGHT)
  - stereo_frame_t struct {left, right}, also used by the transmit path
- One sub-module: i2s_rx_fifo. Synchronous FIFO of stereo_frame_t with push/pop, full/empty, and the simultaneous push/pop-when-full rule.

Test Plan:
- Bench stimulus: SCLK = CLK/8, 32-bit slots, sample_ready=1.
- After reset, send L=24'h123456, R=24'hABCDEF preceded by one sync frame → exactly one frame out with those values, overflow=0, frame_err=0.
- Start the stream mid-right-slot → partial data discarded; first output pair is the next complete L/R frame; no frame_err.
- 16-bit slots carrying L=16'hBEEF, R=16'h1234 → sample_left=24'hBEEF00, sample_right=24'h123400, frame_err=1; clear_status → frame_err=0.
- sample_ready=0, send 5 frames (values 1..5) → sample_valid=1, overflow=1. Drain yields 1, 2, 3, 4; frame 5 is lost.
- FIFO full, sample_ready=1 asserted on the push cycle → frame accepted, overflow stays 0, order preserved.
- With I2S_RX_PEAK_EN, L=24'h800000 then 24'h000010 → peak_left=24'h7FFFFF. peak_clear → 0; next frame L=24'hFFFFF0 → peak_left=24'h000010.
